detection_sm_multi: RTL and testbench

- Parametrised successor to the single-pass detection state machine.
- Sequences one frame capture, then N_WIN back-to-back classifier passes (windows/scales) over the stored frame, and collects a per-window hit mask.
- Owns the frame-buffer port-A mux: camera write address during capture, classifier read address during detection.
- Adds a per-pass timeout and an auto-run mode for continuous operation without the continue button.

---
 rtl/detection_sm_multi.sv | 170 +++++++++++++++++
 tb/tb_detection_sm_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/detection_sm_multi.sv
// detection_sm_multi: sequences one frame capture followed by N_WIN back-to-back
// classifier passes over the stored frame and collects a per-pass hit mask.
// It also owns the frame-buffer port-A mux. Each pass has a timeout, and an
// auto-run mode restarts capture after every result.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cont_in, auto_run   start request (pulse) / continuous restart enable
//   cap_done            camera frame complete (rising edge used)
//   write_en_in,wr_addr camera write port, routed to port A during CAPTURE
//   classifier_rd_addr  classifier read address, routed to port A during DETECT
//   detect_done         classifier pass complete (rising edge used)
//   detected_flag       classifier result, sampled on detect_done rise
//   detect_en, win_idx  classifier enable / current pass index
//   address_a_out, write_en_out  frame-buffer port A
//   hit_mask, any_hit   per-pass results and their OR
//   result_valid        one-cycle pulse when results are final
//   timeout_err         a pass in the last frame timed out
//   state_out           IDLE=0, CAPTURE=1, DETECT=2, DONE=3
module detection_sm_multi #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned N_WIN       = 4,
  parameter int unsigned WIN_W       = 2,
  parameter int unsigned TMO_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cont_in,
  input  logic              auto_run,
  input  logic              cap_done,
  input  logic              write_en_in,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] classifier_rd_addr,
  input  logic              detect_done,
  input  logic              detected_flag,
  output logic              detect_en,
  output logic [WIN_W-1:0]  win_idx,
  output logic [ADDR_W-1:0] address_a_out,
  output logic              write_en_out,
  output logic [N_WIN-1:0]  hit_mask,
  output logic              any_hit,
  output logic              result_valid,
  output logic              timeout_err,
  output logic [1:0]        state_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DETECT  = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e             state_q;
  logic               cap_done_q;
  logic               detect_done_q;
  logic               detect_en_q;
  logic [WIN_W-1:0]   win_idx_q;
  logic [N_WIN-1:0]   hit_mask_q;
  logic               any_hit_q;
  logic               result_valid_q;
  logic               timeout_err_q;
  logic [TMO_W-1:0]   tmo_cnt_q;

  logic               cap_rise;
  logic               det_rise;
  logic               tmo_hit;
  logic               pass_end;
  logic               last_pass;
  logic [N_WIN-1:0]   hit_mask_d;

  assign cap_rise  = cap_done & ~cap_done_q;
  assign det_rise  = detect_done & ~detect_done_q;
  assign tmo_hit   = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
  // A pass ends on the classifier answer or on timeout; the answer wins a tie.
  assign pass_end  = (state_q == S_DETECT) && detect_en_q && (det_rise || tmo_hit);
  assign last_pass = (win_idx_q == WIN_W'(N_WIN - 1));

  // Hit mask including the result of a pass ending this cycle.
  always_comb begin
    hit_mask_d = hit_mask_q;
    if (pass_end) begin
      for (int unsigned i = 0; i < N_WIN; i++) begin
        if (WIN_W'(i) == win_idx_q) hit_mask_d[i] = det_rise & detected_flag;
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cap_done_q     <= 1'b0;
      detect_done_q  <= 1'b0;
      detect_en_q    <= 1'b0;
      win_idx_q      <= '0;
      hit_mask_q     <= '0;
      any_hit_q      <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      tmo_cnt_q      <= '0;
    end else begin
      cap_done_q     <= cap_done;
      detect_done_q  <= detect_done;
      result_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cont_in || auto_run) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (cap_rise) begin
            state_q       <= S_DETECT;
            detect_en_q   <= 1'b1;
            win_idx_q     <= '0;
            hit_mask_q    <= '0;
            any_hit_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= '0;
          end
        end
        S_DETECT: begin
          if (detect_en_q) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            if (pass_end) begin
              detect_en_q <= 1'b0;
              hit_mask_q  <= hit_mask_d;
              if (!det_rise) timeout_err_q <= 1'b1;
              if (last_pass) begin
                state_q        <= S_DONE;
                result_valid_q <= 1'b1;
                any_hit_q      <= |hit_mask_d;
              end
            end
          end else begin
            // One-cycle classifier restart gap between passes.
            win_idx_q   <= win_idx_q + WIN_W'(1);
            tmo_cnt_q   <= '0;
            detect_en_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Frame-buffer port-A mux, decoded from state.
  always_comb begin
    address_a_out = '0;
    write_en_out  = 1'b0;
    if (state_q == S_CAPTURE) begin
      address_a_out = wr_addr;
      write_en_out  = write_en_in;
    end else if (state_q == S_DETECT) begin
      address_a_out = classifier_rd_addr;
    end
  end

  assign detect_en    = detect_en_q;
  assign win_idx      = win_idx_q;
  assign hit_mask     = hit_mask_q;
  assign any_hit      = any_hit_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_detection_sm_multi.sv
// Bench for detection_sm_multi: directed and randomized frames, each pass's
// classifier response (delay, flag, silence) chosen up front; expected pass
// lengths, hit mask and timeout flag are derived from those choices.
module tb_detection_sm_multi;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned N_WIN  = 4;
  localparam int unsigned WIN_W  = 2;
  localparam int unsigned TMO_W  = 16;
  localparam int unsigned TMO    = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              cont_in;
  logic              auto_run;
  logic              cap_done;
  logic              write_en_in;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] classifier_rd_addr;
  logic              detect_done;
  logic              detected_flag;
  logic              detect_en;
  logic [WIN_W-1:0]  win_idx;
  logic [ADDR_W-1:0] address_a_out;
  logic              write_en_out;
  logic [N_WIN-1:0]  hit_mask;
  logic              any_hit;
  logic              result_valid;
  logic              timeout_err;
  logic [1:0]        state_out;

  always #5 clk = ~clk;

  detection_sm_multi #(
    .ADDR_W(ADDR_W), .N_WIN(N_WIN), .WIN_W(WIN_W), .TMO_W(TMO_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .cont_in(cont_in), .auto_run(auto_run),
    .cap_done(cap_done), .write_en_in(write_en_in), .wr_addr(wr_addr),
    .classifier_rd_addr(classifier_rd_addr), .detect_done(detect_done),
    .detected_flag(detected_flag), .detect_en(detect_en), .win_idx(win_idx),
    .address_a_out(address_a_out), .write_en_out(write_en_out),
    .hit_mask(hit_mask), .any_hit(any_hit), .result_valid(result_valid),
    .timeout_err(timeout_err), .state_out(state_out)
  );

  int checks   = 0;
  int failures = 0;

  // Per-pass classifier behaviour for the next frame.
  int dly [N_WIN];
  bit flg [N_WIN];
  bit sil [N_WIN];
  bit prev_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One frame: start (unless already capturing), capture, N_WIN passes, result.
  // abort_pass >= 0 resets the design five cycles into that pass.
  task automatic do_frame(input int abort_pass, input bit hold_cap);
    logic [N_WIN-1:0] exp_mask;
    logic             exp_err;
    int               elapsed;
    int               exp_len;
    bit               answered;
    exp_mask = '0;
    exp_err  = 1'b0;
    if (hold_cap) cap_done = 1'b1;
    if (state_out !== 2'd1) begin
      chk("idle_before_start", 32'(state_out), 32'd0);
      cont_in = ~auto_run;
      tick();
      cont_in = 1'b0;
    end
    chk("capture_entered", 32'(state_out), 32'd1);
    write_en_in = 1'b1;
    wr_addr     = ADDR_W'($urandom);
    #1;
    chk("cap_addr_mux", 32'(address_a_out), 32'(wr_addr));
    chk("cap_we_mux", 32'(write_en_out), 32'd1);
    chk("cap_err_held", 32'(timeout_err), 32'(prev_err));
    if (hold_cap) begin
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("cap_level_no_trigger", 32'(state_out), 32'd1);
      end
    end
    cap_done = 1'b0;
    tick();
    tick();
    chk("cap_wait_low", 32'(state_out), 32'd1);
    cap_done           = 1'b1;
    classifier_rd_addr = ADDR_W'($urandom);
    tick();
    chk("detect_entered", 32'(state_out), 32'd2);
    chk("detect_en_first", 32'(detect_en), 32'd1);
    chk("win_start", 32'(win_idx), 32'd0);
    chk("mask_cleared", 32'(hit_mask), 32'd0);
    chk("err_cleared", 32'(timeout_err), 32'd0);
    chk("det_we_mux", 32'(write_en_out), 32'd0);
    chk("det_addr_mux", 32'(address_a_out), 32'(classifier_rd_addr));
    write_en_in = 1'b0;

    for (int p = 0; p < int'(N_WIN); p++) begin
      answered = !sil[p] && (dly[p] <= int'(TMO) - 1);
      exp_len  = answered ? dly[p] + 1 : int'(TMO);
      if (answered) exp_mask[p] = flg[p];
      else          exp_err     = 1'b1;
      elapsed = 0;
      while (1) begin
        if (p == abort_pass && elapsed == 5) begin
          auto_run = 1'b0;
          rst = 1'b1;
          tick();
          rst         = 1'b0;
          cap_done    = 1'b0;
          detect_done = 1'b0;
          chk("abort_state", 32'(state_out), 32'd0);
          chk("abort_detect_en", 32'(detect_en), 32'd0);
          chk("abort_mask", 32'(hit_mask), 32'd0);
          chk("abort_win", 32'(win_idx), 32'd0);
          chk("abort_valid", 32'(result_valid), 32'd0);
          for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_valid", 32'(result_valid), 32'd0);
          end
          prev_err = 1'b0;
          return;
        end
        if (!sil[p] && elapsed == dly[p]) begin
          detect_done   = 1'b1;
          detected_flag = flg[p];
        end
        tick();
        elapsed++;
        if (detect_en == 1'b0 || elapsed > int'(TMO) + 4) break;
      end
      chk($sformatf("pass%0d_len", p), 32'(elapsed), 32'(exp_len));
      detect_done   = 1'b0;
      detected_flag = 1'($urandom);
      if (p < int'(N_WIN) - 1) begin
        chk("gap_detect_en", 32'(detect_en), 32'd0);
        chk("gap_state", 32'(state_out), 32'd2);
        chk("gap_win", 32'(win_idx), 32'(p));
        chk("gap_mask", 32'(hit_mask), 32'(exp_mask));
        tick();
        chk("next_detect_en", 32'(detect_en), 32'd1);
        chk("next_win", 32'(win_idx), 32'(p + 1));
      end else begin
        chk("done_state", 32'(state_out), 32'd3);
        chk("done_valid", 32'(result_valid), 32'd1);
        chk("done_mask", 32'(hit_mask), 32'(exp_mask));
        chk("done_any", 32'(any_hit), 32'(|exp_mask));
        chk("done_err", 32'(timeout_err), 32'(exp_err));
        chk("done_mux_idle", 32'(address_a_out), 32'd0);
      end
    end
    tick();
    chk("post_idle", 32'(state_out), 32'd0);
    chk("post_valid_low", 32'(result_valid), 32'd0);
    chk("post_mask_hold", 32'(hit_mask), 32'(exp_mask));
    chk("post_win_hold", 32'(win_idx), 32'(N_WIN - 1));
    chk("post_err_hold", 32'(timeout_err), 32'(exp_err));
    prev_err = exp_err;
    if (auto_run) begin
      tick();
      chk("auto_recapture", 32'(state_out), 32'd1);
    end
  endtask

  task automatic set_passes(input int d, input bit f);
    for (int p = 0; p < int'(N_WIN); p++) begin
      dly[p] = d;
      flg[p] = f;
      sil[p] = 1'b0;
    end
  endtask

  task automatic rand_passes();
    for (int p = 0; p < int'(N_WIN); p++) begin
      dly[p] = int'($urandom_range(0, 70));
      flg[p] = 1'($urandom);
      sil[p] = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cont_in = 1'b0; auto_run = 1'b0; cap_done = 1'b0;
    write_en_in = 1'b0; wr_addr = '0; classifier_rd_addr = '0;
    detect_done = 1'b0; detected_flag = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_detect_en", 32'(detect_en), 32'd0);
    chk("rst_addr", 32'(address_a_out), 32'd0);
    chk("rst_we", 32'(write_en_out), 32'd0);
    chk("rst_mask", 32'(hit_mask), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    chk("rst_win", 32'(win_idx), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_no_start", 32'(state_out), 32'd0);

    // Held cap_done, then four passes answering 0,1,0,1 after 20 cycles.
    set_passes(20, 1'b1);
    flg[0] = 1'b0; flg[2] = 1'b0;
    do_frame(-1, 1'b1);

    // Pass 2 silent: times out, others hit.
    set_passes(20, 1'b1);
    sil[2] = 1'b1;
    do_frame(-1, 1'b0);

    // Clean frame clears the error at its detect entry.
    set_passes(7, 1'b0);
    flg[1] = 1'b1;
    do_frame(-1, 1'b0);

    // Answer lands on the timeout cycle: the answer wins.
    set_passes(int'(TMO) - 1, 1'b1);
    do_frame(-1, 1'b0);

    // One cycle late: timeout instead.
    set_passes(int'(TMO) - 1, 1'b1);
    dly[3] = int'(TMO);
    do_frame(-1, 1'b0);

    for (int f = 0; f < 6; f++) begin
      rand_passes();
      do_frame(-1, 1'b0);
    end

    // Continuous operation without cont_in.
    auto_run = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_passes();
      do_frame(-1, 1'b0);
    end

    // Reset in the middle of pass 2.
    set_passes(10, 1'b1);
    do_frame(2, 1'b0);

    rand_passes();
    do_frame(-1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
